// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game score path.
package snake_pkg;

  localparam int unsigned SCORE_W           = 7;
  localparam int unsigned SCORE_MAX_DEFAULT = 99;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_PLAY = 2'd1,
    PH_OVER = 2'd2
  } phase_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the input once and flags a 0->1 transition.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/snake_score_keeper.sv
// Saturating score counter and game-phase FSM feeding the two-digit display.
// Optional session best / OVER-phase display alternation: SNAKE_HIGH_SCORE_EN.
module snake_score_keeper
  import snake_pkg::*;
#(
  parameter int unsigned POINTS     = 1,
  parameter int unsigned SCORE_MAX  = SCORE_MAX_DEFAULT,
  parameter int unsigned ALT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               eat,
  input  logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [SCORE_W-1:0] disp_score,
  output logic [1:0]         phase,
  output logic               new_record,
  output logic               show_high
);

  localparam int unsigned SUM_W = 8;

  // Decoder can only render a tens digit up to 9.
  if (SCORE_MAX > 99 || POINTS < 1 || POINTS > 99 || ALT_CYCLES < 1) begin : g_bad_cfg
    $error("snake_score_keeper: illegal parameter set");
  end

  phase_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] disp_q, disp_d;
  logic [SUM_W-1:0]   sum_c;
  logic [SCORE_W-1:0] score_inc_c;
  logic               eat_rise_c;

`ifdef SNAKE_HIGH_SCORE_EN
  localparam int unsigned CNT_W = (ALT_CYCLES > 1) ? $clog2(ALT_CYCLES) : 1;

  logic [SCORE_W-1:0] high_q, high_d;
  logic               rec_q, rec_d;
  logic               show_q, show_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  rise_detect u_eat_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (eat),
    .rise_c (eat_rise_c)
  );

  // Widened add so the saturation compare never sees a wrapped sum.
  assign sum_c       = SUM_W'(score_q) + SUM_W'(POINTS);
  assign score_inc_c = (sum_c > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                   : sum_c[SCORE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_IDLE;
      score_q <= '0;
      disp_q  <= '0;
`ifdef SNAKE_HIGH_SCORE_EN
      high_q  <= '0;
      rec_q   <= 1'b0;
      show_q  <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      disp_q  <= disp_d;
`ifdef SNAKE_HIGH_SCORE_EN
      high_q  <= high_d;
      rec_q   <= rec_d;
      show_q  <= show_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
`ifdef SNAKE_HIGH_SCORE_EN
    high_d  = high_q;
    rec_d   = rec_q;
    show_d  = show_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      PH_IDLE: begin
        if (start) begin
          state_d = PH_PLAY;
          score_d = '0;
        end
      end
      PH_PLAY: begin
        // Eat is applied before the game-over record compare.
        if (eat_rise_c) score_d = score_inc_c;
        if (game_over) begin
          state_d = PH_OVER;
`ifdef SNAKE_HIGH_SCORE_EN
          cnt_d  = '0;
          show_d = 1'b0;
          rec_d  = (score_d > high_q);
          if (score_d > high_q) high_d = score_d;
`endif
        end
      end
      PH_OVER: begin
        if (start) begin
          state_d = PH_PLAY;
          score_d = '0;
`ifdef SNAKE_HIGH_SCORE_EN
          rec_d   = 1'b0;
          show_d  = 1'b0;
          cnt_d   = '0;
`endif
        end else begin
`ifdef SNAKE_HIGH_SCORE_EN
          if (cnt_q == CNT_W'(ALT_CYCLES - 1)) begin
            cnt_d  = '0;
            show_d = ~show_q;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: state_d = PH_IDLE;
    endcase

`ifdef SNAKE_HIGH_SCORE_EN
    disp_d = (state_d == PH_OVER && show_d) ? high_d : score_d;
`else
    disp_d = score_d;
`endif
  end

  assign score      = score_q;
  assign disp_score = disp_q;
  assign phase      = state_q;
`ifdef SNAKE_HIGH_SCORE_EN
  assign high_score = high_q;
  assign new_record = rec_q;
  assign show_high  = show_q;
`else
  assign high_score = '0;
  assign new_record = 1'b0;
  assign show_high  = 1'b0;
`endif

endmodule

// File: tb/tb_snake_score_keeper.sv
// Directed self-checking bench for snake_score_keeper (ALT_CYCLES shortened to 8).
module tb_snake_score_keeper;

`ifdef SNAKE_HIGH_SCORE_EN
  localparam int HS = 1;
`else
  localparam int HS = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       eat;
  logic       game_over;
  logic [6:0] score;
  logic [6:0] high_score;
  logic [6:0] disp_score;
  logic [1:0] phase;
  logic       new_record;
  logic       show_high;

  int checks = 0;
  int errors = 0;

  snake_score_keeper #(
    .POINTS     (1),
    .SCORE_MAX  (99),
    .ALT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .eat        (eat),
    .game_over  (game_over),
    .score      (score),
    .high_score (high_score),
    .disp_score (disp_score),
    .phase      (phase),
    .new_record (new_record),
    .show_high  (show_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eat_event();
    eat = 1'b1;
    tick();
    eat = 1'b0;
    tick();
  endtask

  task automatic check_all(input string tag, input int s, input int h, input int d,
                           input int p, input int r, input int sh);
    chk({tag, ".score"},      32'(score),      32'(s));
    chk({tag, ".high_score"}, 32'(high_score), 32'(h));
    chk({tag, ".disp_score"}, 32'(disp_score), 32'(d));
    chk({tag, ".phase"},      32'(phase),      32'(p));
    chk({tag, ".new_record"}, 32'(new_record), 32'(r));
    chk({tag, ".show_high"},  32'(show_high),  32'(sh));
  endtask

  initial begin
    int exp_s;
    int exp_sh;
    rst_n     = 1'b0;
    start     = 1'b0;
    eat       = 1'b0;
    game_over = 1'b0;
    repeat (3) tick();
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Eat and game_over in IDLE do nothing.
    eat_event();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check_all("idle_ignore", 0, 0, 0, 0, 0, 0);

    // Game 1: three 5-cycle eat pulses count once each.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("start1", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      eat = 1'b1;
      repeat (5) tick();
      eat = 1'b0;
      repeat (2) tick();
    end
    check_all("three_eats", 3, 0, 3, 1, 0, 0);

    // Start is ignored while playing.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("play_start_ignored", 32'(score), 32'(3));

    repeat (6) eat_event();
    chk("score9", 32'(score), 32'(9));

    // Eat edge together with game_over: 9 -> 10, then record compare.
    eat       = 1'b1;
    game_over = 1'b1;
    tick();
    eat       = 1'b0;
    game_over = 1'b0;
    check_all("eat_and_over", 10, HS * 10, 10, 2, HS, 0);

    // Eat in OVER ignored.
    eat_event();
    chk("over_eat_ignored", 32'(score), 32'(10));

    // Game 2: ends at 4 below best of 10, display alternates.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("start2", 0, HS * 10, 0, 1, 0, 0);
    repeat (4) eat_event();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check_all("over2", 4, HS * 10, 4, 2, 0, 0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_sh = HS * ((k / 8) % 2);
      chk($sformatf("alt_show_k%0d", k), 32'(show_high), 32'(exp_sh));
      chk($sformatf("alt_disp_k%0d", k), 32'(disp_score), 32'(exp_sh != 0 ? 10 : 4));
    end
    chk("over2_new_record", 32'(new_record), 32'(0));

    eat = 1'b1;
    repeat (3) tick();
    eat = 1'b0;
    tick();
    chk("over2_eat_ignored", 32'(score), 32'(4));

    // Start and game_over together in OVER: start wins.
    start     = 1'b1;
    game_over = 1'b1;
    tick();
    start     = 1'b0;
    game_over = 1'b0;
    check_all("restart3", 0, HS * 10, 0, 1, 0, 0);

    // Game 3: 120 eat events saturate at 99.
    for (int i = 1; i <= 120; i++) begin
      eat_event();
      exp_s = (i > 99) ? 99 : i;
      chk($sformatf("sat_i%0d", i), 32'(score), 32'(exp_s));
    end
    chk("sat_disp", 32'(disp_score), 32'(99));
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check_all("over3", 99, HS * 99, 99, 2, HS, 0);

    // Game 4: asynchronous reset mid-play at score 42.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (42) eat_event();
    chk("score42", 32'(score), 32'(42));
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_all("post_reset", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
